rxlogic: RTL and testbench

UART receiver: the receive end of the 8-N-1 serial link driven by `txlogic`. It synchronises the asynchronous `rx` line into the system clock domain and oversamples it 16x. It recovers start/data/stop framing, LSB first, and presents each received byte to the processor interface with a valid/ack handshake. It sits beside `txlogic` under the top-level UART module and shares the 50 MHz system clock.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/rxlogic.sv | 184 ++++++++++++++++++
 tb/tb_rxlogic.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for rxlogic and txlogic.
// RXLOGIC_PARITY_EN adds the PARITY receive state.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RXLOGIC_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every CLK_DIV clocks, restarted by clr.
module uart_baud_tick #(
  parameter int unsigned CLK_DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = 12;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST) && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 12'd1;
    end
  end

endmodule

// File: rtl/rxlogic.sv
// UART 8-N-1 receiver with 16x oversampling and valid/ack byte handoff.
// Define RXLOGIC_PARITY_EN for 8-E-1 framing with an rx_parity_err pulse.
module rxlogic
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data_out,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_overrun
`ifdef RXLOGIC_PARITY_EN
  ,
  output logic       rx_parity_err
`endif
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MID = SW'(MID_SAMPLE);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic          rx_meta, rxs, rxs_q;
  rx_state_e     state_q, state_d;
  logic [SW-1:0] scnt;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          tick, mid, cnt_clr;
  logic          bit_clr, shift_en, done_ok, done_bad;
`ifdef RXLOGIC_PARITY_EN
  logic          par_bit, par_cap;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_q   <= rxs;
    end
  end

  // Timing restarts from the start edge; idle and post-error states hold it cleared
  assign cnt_clr = !rx_en || (state_q == IDLE) || (state_q == WAIT_HIGH);

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst),
    .clr  (cnt_clr),
    .tick (tick)
  );

  assign mid = tick && (scnt == MID);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt <= '0;
    end else if (cnt_clr) begin
      scnt <= '0;
    end else if (tick) begin
      scnt <= scnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    done_ok  = 1'b0;
    done_bad = 1'b0;
`ifdef RXLOGIC_PARITY_EN
    par_cap  = 1'b0;
`endif
    if (!rx_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (rxs_q && !rxs) state_d = START;
        START: begin
          if (mid) begin
            if (!rxs) begin
              state_d = DATA;
              bit_clr = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          if (mid) begin
            shift_en = 1'b1;
            if (bitcnt == LAST_BIT) begin
`ifdef RXLOGIC_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef RXLOGIC_PARITY_EN
        PARITY: begin
          if (mid) begin
            par_cap = 1'b1;
            state_d = STOP;
          end
        end
`endif
        STOP: begin
          if (mid) begin
            if (rxs) begin
              done_ok = 1'b1;
              state_d = IDLE;
            end else begin
              done_bad = 1'b1;
              state_d  = WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: if (rxs) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitcnt <= '0;
      shreg  <= '0;
    end else if (bit_clr) begin
      bitcnt <= '0;
    end else if (shift_en) begin
      shreg[bitcnt] <= rxs;
      bitcnt        <= bitcnt + 3'd1;
    end
  end

  // Completion beats a same-cycle ack, so a fresh byte is never lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_out  <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= done_bad;
      rx_overrun   <= done_ok && rx_valid && !rx_ack;
      if (done_ok) begin
        rx_data_out <= shreg;
        rx_valid    <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef RXLOGIC_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bit       <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      if (par_cap) par_bit <= rxs;
      rx_parity_err <= done_ok && (^{shreg, par_bit});
    end
  end
`endif

endmodule

// File: tb/tb_rxlogic.sv
// Self-checking bench for rxlogic: vector table of frames plus scoreboarded corner sequences.
module tb_rxlogic;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned BIT = 16 * CLK_DIV;
`ifdef RXLOGIC_PARITY_EN
  localparam int unsigned LAT = 611 + BIT;
`else
  localparam int unsigned LAT = 611;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_en = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data_out;
  logic       rx_valid, rx_frame_err, rx_overrun;
`ifdef RXLOGIC_PARITY_EN
  logic       rx_parity_err;
`endif

  always #5 clk = ~clk;

  rxlogic #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_en       (rx_en),
    .rx          (rx),
    .rx_ack      (rx_ack),
    .rx_data_out (rx_data_out),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_overrun  (rx_overrun)
`ifdef RXLOGIC_PARITY_EN
    ,
    .rx_parity_err(rx_parity_err)
`endif
  );

  int total = 0;
  int bad = 0;
  int load_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a load is valid rising, valid held across an ack, or an overrun pulse
  logic pv = 1'b0, pa = 1'b0, pferr = 1'b0, povr = 1'b0, pperr = 1'b0;
  always @(negedge clk) begin
    if (rx_valid && (!pv || pa || rx_overrun)) begin
      load_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_load: got %0h expected no load", rx_data_out);
      end else begin
        check("sb_data", rx_data_out, exp_q.pop_front());
      end
    end
    if (rx_frame_err) begin
      ferr_cnt++;
      check("ferr_width", pferr, 0);
    end
    if (rx_overrun) begin
      ovr_cnt++;
      check("ovr_width", povr, 0);
    end
`ifdef RXLOGIC_PARITY_EN
    if (rx_parity_err) begin
      perr_cnt++;
      check("perr_width", pperr, 0);
    end
    pperr = rx_parity_err;
`endif
    pv    = rx_valid;
    pa    = rx_ack;
    pferr = rx_frame_err;
    povr  = rx_overrun;
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit par_flip,
                           input bit push);
    if (push) exp_q.push_back(b);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (BIT) @(posedge clk);
    end
`ifdef RXLOGIC_PARITY_EN
    #1 rx = (^b) ^ par_flip;
    repeat (BIT) @(posedge clk);
`else
    if (par_flip) begin end
`endif
    if (stop_ok) begin
      #1 rx = 1'b1;
      repeat (BIT) @(posedge clk);
    end else begin
      #1 rx = 1'b0;
      repeat (2 * BIT) @(posedge clk);
      #1 rx = 1'b1;
      repeat (BIT) @(posedge clk);
    end
  endtask

  task automatic wait_load(input int n0, input int budget);
    for (int i = 0; i < budget && load_cnt <= n0; i++) @(negedge clk);
    check("load_timeout", load_cnt > n0, 1);
  endtask

  task automatic ack_pulse();
    @(posedge clk);
    #1 rx_ack = 1'b1;
    @(posedge clk);
    #1 rx_ack = 1'b0;
    check("ack_clears_valid", rx_valid, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         ack;
    logic [7:0] exp_dout;
    bit         exp_valid;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, f0, o0, p0;
    vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 0, 0};
    vecs[1] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 0, 0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'hA3, 1'b0, 1, 0};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 0, 0};
    vecs[4] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 0, 0};
    vecs[5] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 0, 1};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 0, 0};
    vecs[7] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", rx_data_out, 8'h00);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", rx_frame_err, 0);
    check("rst_ovr", rx_overrun, 0);
    rst = 1'b1;
    repeat (4) @(posedge clk);

    foreach (vecs[i]) begin
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      send_byte(vecs[i].data, vecs[i].stop_ok, 1'b0, vecs[i].stop_ok);
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_dout", i), rx_data_out, vecs[i].exp_dout);
      check($sformatf("v%0d_valid", i), rx_valid, vecs[i].exp_valid);
      check($sformatf("v%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("v%0d_ovr", i), ovr_cnt - o0, vecs[i].exp_ovr);
      if (vecs[i].ack) ack_pulse();
    end

    // Back-to-back frames with no idle gap, acked while the next is arriving
    n0 = load_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    fork
      begin
        send_byte(8'h55, 1'b1, 1'b0, 1'b1);
        send_byte(8'hF0, 1'b1, 1'b0, 1'b1);
      end
      begin
        wait_load(n0, 1500);
        ack_pulse();
        wait_load(n0 + 1, 1500);
        ack_pulse();
      end
    join
    check("b2b_loads", load_cnt - n0, 2);
    check("b2b_dout", rx_data_out, 8'hF0);
    check("b2b_errs", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    // Short low glitch must not start a frame
    n0 = load_cnt; f0 = ferr_cnt;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (20) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    check("glitch_loads", load_cnt - n0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_valid", rx_valid, 0);
    send_byte(8'hA3, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("glitch_next_dout", rx_data_out, 8'hA3);
    check("glitch_next_loads", load_cnt - n0, 1);
    ack_pulse();

    // Ack landing exactly on the completion cycle: no overrun, valid stays set
    send_byte(8'h11, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("ackwin_pre_valid", rx_valid, 1);
    o0 = ovr_cnt;
    fork
      send_byte(8'h22, 1'b1, 1'b0, 1'b1);
      begin
        repeat (LAT) @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
        check("ackwin_valid", rx_valid, 1);
      end
    join
    check("ackwin_ovr", ovr_cnt - o0, 0);
    check("ackwin_dout", rx_data_out, 8'h22);
    ack_pulse();

    // Asynchronous reset during bit 3
    send_byte(8'h7E, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("rstmid_pre_valid", rx_valid, 1);
    n0 = load_cnt;
    fork
      send_byte(8'hFF, 1'b1, 1'b1, 1'b0);
      begin
        repeat (4 * BIT + BIT / 2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rstmid_dout", rx_data_out, 8'h00);
        check("rstmid_valid", rx_valid, 0);
        check("rstmid_ferr", rx_frame_err, 0);
        check("rstmid_ovr", rx_overrun, 0);
        @(posedge clk);
        #1 rst = 1'b1;
      end
    join
    check("rstmid_loads", load_cnt - n0, 0);
    send_byte(8'h81, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("rstmid_next_dout", rx_data_out, 8'h81);
    check("rstmid_next_valid", rx_valid, 1);
    ack_pulse();

    // Receiver disabled mid-frame for the rest of the frame
    n0 = load_cnt; f0 = ferr_cnt;
    fork
      send_byte(8'h5A, 1'b1, 1'b0, 1'b0);
      begin
        repeat (300) @(posedge clk);
        #1 rx_en = 1'b0;
      end
    join
    @(posedge clk);
    #1 rx_en = 1'b1;
    repeat (BIT) @(posedge clk);
    check("en_loads", load_cnt - n0, 0);
    check("en_ferr", ferr_cnt - f0, 0);
    check("en_valid", rx_valid, 0);
    check("en_dout", rx_data_out, 8'h81);
    send_byte(8'hC3, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("en_next_dout", rx_data_out, 8'hC3);
    check("en_next_valid", rx_valid, 1);
    ack_pulse();

`ifdef RXLOGIC_PARITY_EN
    p0 = perr_cnt;
    send_byte(8'h0F, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("par_err", perr_cnt - p0, 1);
    check("par_valid", rx_valid, 1);
    check("par_dout", rx_data_out, 8'h0F);
    ack_pulse();
    check("par_total", perr_cnt, 1);
`else
    p0 = 0;
    check("par_none", perr_cnt + p0, 0);
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
